// File: rtl/serial_link_pkg.sv
// Definitions shared by both ends of the shift-register serial link: FSM state
// encodings and the line levels of the framing bits.
package serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } link_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sipo_shift_reg.sv
// Enable-gated serial-in/parallel-out shift register. LSB_FIRST=1 shifts toward
// bit 0, so the first bit in ends up in q[0] after N shifts.
module sipo_shift_reg #(
  parameter int N         = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         bit_in,
  output logic [N-1:0] q
);

  generate
    if (LSB_FIRST) begin : g_lsb_first
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  q <= '0;
        else if (en)   q <= {bit_in, q[N-1:1]};
      end
    end else begin : g_msb_first
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  q <= '0;
        else if (en)   q <= {q[N-2:0], bit_in};
      end
    end
  endgenerate

endmodule

// File: rtl/serial_frame_receiver.sv
// Framed serial receiver: start bit, N data bits, optional even parity bit
// (SERIAL_FRAME_RX_PARITY_EN), stop bit; word presented on a valid/ready port.
module serial_frame_receiver
  import serial_link_pkg::*;
#(
  parameter int N         = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ser_in,
  input  logic         ser_valid,
  output logic [N-1:0] data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         frame_err,
  output logic         overrun,
  output logic         parity_err,
  output link_state_e  state
);

  // Output handshake: a word transfers on any edge where out_valid & out_ready.
  // data_out is stable while out_valid is high and nothing transfers.
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] cnt;
  logic [N-1:0]  sr;
  logic          shift_en;

  assign shift_en = ser_valid && (state == DATA);

  sipo_shift_reg #(.N(N), .LSB_FIRST(LSB_FIRST)) u_sr (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (shift_en),
    .bit_in (ser_in),
    .q      (sr)
  );

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic par_bad;
  logic parity_err_r;
  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (ser_valid) begin
        case (state)
          IDLE: begin
            if (ser_in == START_BIT) begin
              state <= DATA;
              cnt   <= '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
              par_bad <= 1'b0;
`endif
            end
          end
          DATA: begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(N - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
`ifdef SERIAL_FRAME_RX_PARITY_EN
          PARITY: begin
            // Even parity: the parity bit must equal the XOR of the data bits.
            par_bad <= (ser_in != ^sr);
            state   <= STOP;
          end
`endif
          STOP: begin
            state <= IDLE;
            if (ser_in != STOP_BIT) begin
              frame_err <= 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            end else if (par_bad) begin
              parity_err_r <= 1'b1;
`endif
            end else if (!out_valid || out_ready) begin
              data_out  <= sr;
              out_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver (N=4, LSB_FIRST=1): directed frames plus random
// traffic checked against a frame-level model of the line protocol.
module tb_serial_frame_receiver;
  import serial_link_pkg::*;

  localparam int N         = 4;
  localparam bit LSB_FIRST = 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         ser_in;
  logic         ser_valid;
  logic         out_ready;
  logic [N-1:0] data_out;
  logic         out_valid;
  logic         frame_err;
  logic         overrun;
  logic         parity_err;
  link_state_e  state;

  serial_frame_receiver #(.N(N), .LSB_FIRST(LSB_FIRST)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err),
    .state     (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: frame-level view of the line plus the word port
  bit           m_in_frame;
  int           m_bits[$];
  logic         m_valid;
  logic [N-1:0] m_data;
  logic         e_ferr, e_ovr, e_perr;
  logic [N-1:0] exp_q[$];

  function automatic logic [N-1:0] assemble();
    logic [N-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      if (LSB_FIRST) w[i] = m_bits[i][0];
      else           w[N-1-i] = m_bits[i][0];
    end
    return w;
  endfunction

  task automatic model_reset();
    m_in_frame = 0;
    m_bits.delete();
    m_valid = 1'b0;
    m_data  = '0;
    e_ferr = 1'b0; e_ovr = 1'b0; e_perr = 1'b0;
    exp_q.delete();
  endtask

  // driver: present one cycle of inputs, advance the model, check after the edge
  task automatic step(input logic b, input logic v, input logic r);
    logic         commit, accept;
    logic [N-1:0] word;
    int           ones;
    ser_in = b; ser_valid = v; out_ready = r;
    commit = 1'b0;
    word   = '0;
    accept = m_valid && r;
    if (accept) check("accept_word", data_out, exp_q.pop_front());
    e_ferr = 1'b0; e_ovr = 1'b0; e_perr = 1'b0;
    if (v) begin
      if (!m_in_frame) begin
        if (b == 1'b0) begin
          m_in_frame = 1;
          m_bits.delete();
        end
      end else begin
        m_bits.push_back(int'(b));
        if (m_bits.size() == N + P + 1) begin
          m_in_frame = 0;
          word = assemble();
          ones = 0;
          for (int i = 0; i < N + P; i++) ones += m_bits[i];
          if (b == 1'b0)                e_ferr = 1'b1;
          else if (P == 1 && ones % 2)  e_perr = 1'b1;
          else                          commit = 1'b1;
        end
      end
    end
    if (commit) begin
      if (m_valid && !r) e_ovr = 1'b1;
      else begin
        m_data  = word;
        m_valid = 1'b1;
        exp_q.push_back(word);
      end
    end else if (accept) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_valid);
    check("data_out", data_out, m_data);
    check("frame_err", frame_err, e_ferr);
    check("overrun", overrun, e_ovr);
    check("parity_err", parity_err, e_perr);
  endtask

  task automatic send_frame(input logic [N-1:0] w, input logic stop, input bit par_ok,
                            input logic r_body, input logic r_stop);
    step(1'b0, 1'b1, r_body);
    for (int i = 0; i < N; i++) step(LSB_FIRST ? w[i] : w[N-1-i], 1'b1, r_body);
    if (P == 1) step((^w) ^ !par_ok, 1'b1, r_body);
    step(stop, 1'b1, r_stop);
  endtask

  task automatic rand_frame();
    logic         bits[$];
    logic [N-1:0] w;
    w = N'($urandom);
    bits.push_back(1'b0);
    for (int i = 0; i < N; i++) bits.push_back(LSB_FIRST ? w[i] : w[N-1-i]);
    if (P == 1) bits.push_back((^w) ^ ($urandom_range(0, 7) == 0));
    bits.push_back($urandom_range(0, 7) != 0);
    foreach (bits[i]) begin
      while ($urandom_range(0, 3) == 0)
        step(1'($urandom), 1'b0, 1'($urandom));
      step(bits[i], 1'b1, 1'($urandom));
    end
    while ($urandom_range(0, 2) == 0) step(1'b1, 1'b1, 1'($urandom));
  endtask

  initial begin
    reset_n = 1'b0; ser_in = 1'b1; ser_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", data_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_flags", {frame_err, overrun, parity_err}, 0);
    check("rst_state", state, IDLE);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic frame, then accept
    send_frame(4'b1011, 1'b1, 1, 1'b0, 1'b0);
    check("t1_data", data_out, 4'b1011);
    check("t1_valid", out_valid, 1);
    step(1'b1, 1'b0, 1'b1);
    check("t1_accepted", out_valid, 0);

    // 2: bad stop bit, then a good frame
    send_frame(4'b0101, 1'b0, 1, 1'b0, 1'b0);
    check("t2_ferr", frame_err, 1);
    check("t2_data_held", data_out, 4'b1011);
    check("t2_valid", out_valid, 0);
    send_frame(4'b0110, 1'b1, 1, 1'b0, 1'b0);
    check("t2_next", data_out, 4'b0110);
    step(1'b1, 1'b0, 1'b1);

    // 3: overrun keeps the old word
    send_frame(4'b1011, 1'b1, 1, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b1, 1, 1'b0, 1'b0);
    check("t3_overrun", overrun, 1);
    check("t3_data_kept", data_out, 4'b1011);

    // 4: accept on the same edge as commit
    send_frame(4'b0110, 1'b1, 1, 1'b0, 1'b1);
    check("t4_data", data_out, 4'b0110);
    check("t4_valid", out_valid, 1);
    check("t4_no_overrun", overrun, 0);
    step(1'b1, 1'b0, 1'b1);

    // 5: async reset mid-frame with a word pending
    send_frame(4'b0011, 1'b1, 1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("t5_data", data_out, 0);
    check("t5_valid", out_valid, 0);
    check("t5_flags", {frame_err, overrun, parity_err}, 0);
    check("t5_state", state, IDLE);
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(4'b1111, 1'b1, 1, 1'b0, 1'b0);
    check("t5_after", data_out, 4'b1111);
    step(1'b1, 1'b0, 1'b1);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    // 6: parity mismatch drops the word
    send_frame(4'b1011, 1'b1, 0, 1'b0, 1'b0);
    check("t6_perr", parity_err, 1);
    check("t6_no_commit", out_valid, 0);
    send_frame(4'b1011, 1'b1, 1, 1'b0, 1'b0);
    check("t6_commit", data_out, 4'b1011);
    step(1'b1, 1'b0, 1'b1);
`endif

    // back-to-back frames, no idle between stop and start
    send_frame(4'b1001, 1'b1, 1, 1'b1, 1'b1);
    send_frame(4'b0100, 1'b1, 1, 1'b1, 1'b1);
    check("b2b_data", data_out, 4'b0100);
    step(1'b1, 1'b0, 1'b1);

    // random traffic with gaps, errors and back-pressure
    for (int k = 0; k < 400; k++) rand_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
